// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: ROB geometry, entry layout and
// functional-unit counts used by the ROB and reservation-station logic.
package tomasulo_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = $clog2(ROB_DEPTH);
    localparam int CNT_W     = TAG_W + 1;
    localparam int REG_W     = 4;
    localparam int DATA_W    = 16;

    localparam int NUM_ADD_RS = 3;
    localparam int NUM_MUL_RS = 2;
    localparam int NUM_BCH_RS = 1;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              is_bch;
        logic              mispred;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/tomasulo_rob_ptr.sv
// ROB head/tail pointers with natural wrap and the occupancy counter.
module tomasulo_rob_ptr
    import tomasulo_pkg::*;
(
    input  logic             clk1,
    input  logic             rst,
    input  logic             inc_head,
    input  logic             inc_tail,
    input  logic             clear,
    output logic [TAG_W-1:0] head_p,
    output logic [TAG_W-1:0] tail_p,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (inc_head) head_d = head_q + TAG_W'(1);
            if (inc_tail) tail_d = tail_q + TAG_W'(1);
            case ({inc_tail, inc_head})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_p = head_q;
    assign tail_p = tail_q;
    assign count  = count_q;
    assign full   = (count_q == CNT_W'(ROB_DEPTH));
    assign empty  = (count_q == '0);

endmodule

// File: rtl/tomasulo_rob_ctrl.sv
// Reorder-buffer controller: tag allocation, CDB capture, in-order commit
// and whole-buffer flush when a mispredicted branch retires.
module tomasulo_rob_ctrl
    import tomasulo_pkg::*;
(
    input  logic              clk1,
    input  logic              rst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [REG_W-1:0]  alloc_dest,
    input  logic              alloc_is_bch,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispred,
    output logic              commit_valid,
    output logic              commit_we,
    output logic [REG_W-1:0]  commit_dest,
    output logic [DATA_W-1:0] commit_data,
    output logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    rob_entry_t rob_q [ROB_DEPTH];
    rob_entry_t rob_d [ROB_DEPTH];
    rob_entry_t head_e;
    rob_entry_t cdb_e;

    logic [TAG_W-1:0] head_p;
    logic [TAG_W-1:0] tail_p;
    logic alloc_fire, cdb_fire, commit_fire, flush_fire;

    logic              commit_valid_q, commit_valid_d;
    logic              commit_we_q, commit_we_d;
    logic [REG_W-1:0]  commit_dest_q, commit_dest_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;
    logic              flush_q, flush_d;

    tomasulo_rob_ptr u_ptr (
        .clk1     (clk1),
        .rst      (rst),
        .inc_head (commit_fire),
        .inc_tail (alloc_fire),
        .clear    (flush_fire),
        .head_p   (head_p),
        .tail_p   (tail_p),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign head_e      = rob_q[head_p];
    assign cdb_e       = rob_q[cdb_tag];
    assign alloc_ready = !full && !flush_q;
    assign alloc_tag   = tail_p;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign cdb_fire    = cdb_valid && !flush_q && cdb_e.busy && !cdb_e.done;
    assign commit_fire = head_e.busy && head_e.done && !flush_q;
    assign flush_fire  = commit_fire && head_e.mispred;

    // Flush is applied last so it also discards a same-cycle allocation.
    always_comb begin
        rob_d = rob_q;
        if (commit_fire) rob_d[head_p].busy = 1'b0;
        if (alloc_fire) begin
            rob_d[tail_p].busy    = 1'b1;
            rob_d[tail_p].done    = 1'b0;
            rob_d[tail_p].mispred = 1'b0;
            rob_d[tail_p].is_bch  = alloc_is_bch;
            rob_d[tail_p].dest    = alloc_dest;
        end
        if (cdb_fire) begin
            rob_d[cdb_tag].done    = 1'b1;
            rob_d[cdb_tag].value   = cdb_data;
            rob_d[cdb_tag].mispred = cdb_mispred && cdb_e.is_bch;
        end
        if (flush_fire) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_d[i].busy    = 1'b0;
                rob_d[i].done    = 1'b0;
                rob_d[i].mispred = 1'b0;
            end
        end
    end

    always_comb begin
        commit_valid_d = commit_fire;
        commit_we_d    = commit_fire && !head_e.is_bch;
        commit_dest_d  = commit_fire ? head_e.dest : commit_dest_q;
        commit_data_d  = commit_fire ? head_e.value : commit_data_q;
        flush_d        = flush_fire;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
            commit_valid_q <= 1'b0;
            commit_we_q    <= 1'b0;
            commit_dest_q  <= '0;
            commit_data_q  <= '0;
            flush_q        <= 1'b0;
        end else begin
            rob_q          <= rob_d;
            commit_valid_q <= commit_valid_d;
            commit_we_q    <= commit_we_d;
            commit_dest_q  <= commit_dest_d;
            commit_data_q  <= commit_data_d;
            flush_q        <= flush_d;
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_we    = commit_we_q;
    assign commit_dest  = commit_dest_q;
    assign commit_data  = commit_data_q;
    assign flush        = flush_q;

endmodule

// File: tb/tb_tomasulo_rob_ctrl.sv
// Directed bench for tomasulo_rob_ctrl: vector table for in-order commit,
// hand sequences for full/wrap, alloc+commit, flush, CDB filtering, reset.
module tb_tomasulo_rob_ctrl;

    logic        clk1;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_dest;
    logic        alloc_is_bch;
    logic [2:0]  alloc_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        cdb_mispred;
    logic        commit_valid;
    logic        commit_we;
    logic [3:0]  commit_dest;
    logic [15:0] commit_data;
    logic        flush;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    tomasulo_rob_ctrl dut (
        .clk1         (clk1),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_dest   (alloc_dest),
        .alloc_is_bch (alloc_is_bch),
        .alloc_tag    (alloc_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_mispred  (cdb_mispred),
        .commit_valid (commit_valid),
        .commit_we    (commit_we),
        .commit_dest  (commit_dest),
        .commit_data  (commit_data),
        .flush        (flush),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Expected values are the outputs seen before the row's inputs are clocked.
    typedef struct {
        int av, ad, ab, cv, ct, cd, cm;
        int rdy, tag, vld, we, dst, dat, fl, cnt;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid  = 1'b0;
        alloc_dest   = '0;
        alloc_is_bch = 1'b0;
        cdb_valid    = 1'b0;
        cdb_tag      = '0;
        cdb_data     = '0;
        cdb_mispred  = 1'b0;
    endtask

    task automatic cyc(input int av, input int ad, input int ab,
                       input int cv, input int ct, input int cd,
                       input int cm);
        alloc_valid  = av[0];
        alloc_dest   = ad[3:0];
        alloc_is_bch = ab[0];
        cdb_valid    = cv[0];
        cdb_tag      = ct[2:0];
        cdb_data     = cd[15:0];
        cdb_mispred  = cm[0];
        @(posedge clk1);
        @(negedge clk1);
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk1);
        @(negedge clk1);
        rst = 1'b0;
    endtask

    task automatic alloc(input int d, input int b);
        cyc(1, d, b, 0, 0, 0, 0);
    endtask

    task automatic cdb(input int t, input int d, input int m);
        cyc(0, 0, 0, 1, t, d, m);
    endtask

    task automatic step();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        //        av ad ab cv ct cd     cm rdy tag vld we dst dat    fl cnt
        vt[0] = '{1, 1, 0, 0, 0, 0,     0, 1,  0,  0,  0, 0,  0,     0, 0};
        vt[1] = '{1, 2, 0, 0, 0, 0,     0, 1,  1,  0,  0, 0,  0,     0, 1};
        vt[2] = '{1, 3, 0, 0, 0, 0,     0, 1,  2,  0,  0, 0,  0,     0, 2};
        vt[3] = '{0, 0, 0, 1, 2, 'h22,  0, 1,  3,  0,  0, 0,  0,     0, 3};
        vt[4] = '{0, 0, 0, 1, 0, 'h00,  0, 1,  3,  0,  0, 0,  0,     0, 3};
        vt[5] = '{0, 0, 0, 1, 1, 'h11,  0, 1,  3,  0,  0, 0,  0,     0, 3};
        vt[6] = '{0, 0, 0, 0, 0, 0,     0, 1,  3,  1,  1, 1,  'h00,  0, 2};
        vt[7] = '{0, 0, 0, 0, 0, 0,     0, 1,  3,  1,  1, 2,  'h11,  0, 1};
        vt[8] = '{0, 0, 0, 0, 0, 0,     0, 1,  3,  1,  1, 3,  'h22,  0, 0};
        vt[9] = '{0, 0, 0, 0, 0, 0,     0, 1,  3,  0,  0, 0,  0,     0, 0};

        rst = 1'b0;
        idle_inputs();
        do_reset();
        chk("rst_dest", 32'(commit_dest), 0);
        chk("rst_data", 32'(commit_data), 0);

        // 1: in-order commit of out-of-order completions
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t1r%0d_rdy", i), 32'(alloc_ready), vt[i].rdy);
            chk($sformatf("t1r%0d_tag", i), 32'(alloc_tag), vt[i].tag);
            chk($sformatf("t1r%0d_vld", i), 32'(commit_valid), vt[i].vld);
            chk($sformatf("t1r%0d_we", i), 32'(commit_we), vt[i].we);
            chk($sformatf("t1r%0d_fl", i), 32'(flush), vt[i].fl);
            chk($sformatf("t1r%0d_cnt", i), 32'(count), vt[i].cnt);
            chk($sformatf("t1r%0d_full", i), 32'(full), int'(vt[i].cnt == 8));
            chk($sformatf("t1r%0d_empty", i), 32'(empty), int'(vt[i].cnt == 0));
            if (vt[i].vld != 0) begin
                chk($sformatf("t1r%0d_dst", i), 32'(commit_dest), vt[i].dst);
                chk($sformatf("t1r%0d_dat", i), 32'(commit_data), vt[i].dat);
            end
            cyc(vt[i].av, vt[i].ad, vt[i].ab, vt[i].cv, vt[i].ct,
                vt[i].cd, vt[i].cm);
        end

        // 2: fill, refuse 9th, commit tag 0, wrap allocation to tag 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_tag%0d", i), 32'(alloc_tag), i);
            alloc(i, 0);
        end
        chk("t2_full", 32'(full), 1);
        chk("t2_rdy_full", 32'(alloc_ready), 0);
        chk("t2_cnt8", 32'(count), 8);
        alloc(9, 0);
        chk("t2_cnt_9th", 32'(count), 8);
        chk("t2_tail_9th", 32'(alloc_tag), 0);
        cdb(0, 'h55, 0);
        chk("t2_vld_pre", 32'(commit_valid), 0);
        step();
        chk("t2_vld", 32'(commit_valid), 1);
        chk("t2_dst", 32'(commit_dest), 0);
        chk("t2_dat", 32'(commit_data), 'h55);
        chk("t2_cnt7", 32'(count), 7);
        chk("t2_rdy7", 32'(alloc_ready), 1);
        chk("t2_wrap_tag", 32'(alloc_tag), 0);
        alloc(9, 0);
        chk("t2_cnt_wrap", 32'(count), 8);
        chk("t2_full_wrap", 32'(full), 1);
        chk("t2_tail_wrap", 32'(alloc_tag), 1);

        // 3: alloc and commit together at count 4
        do_reset();
        for (int i = 0; i < 4; i++) alloc(i + 4, 0);
        cdb(0, 'h10, 0);
        chk("t3_cnt_pre", 32'(count), 4);
        chk("t3_head_pre", 32'(dut.head_p), 0);
        chk("t3_tail_pre", 32'(alloc_tag), 4);
        alloc(8, 0);
        chk("t3_cnt", 32'(count), 4);
        chk("t3_head", 32'(dut.head_p), 1);
        chk("t3_tail", 32'(alloc_tag), 5);
        chk("t3_vld", 32'(commit_valid), 1);
        chk("t3_dat", 32'(commit_data), 'h10);

        // 4: mispredicted branch at tag 1 flushes tag 2
        do_reset();
        alloc(5, 0);
        alloc(0, 1);
        alloc(7, 0);
        cdb(1, 'h99, 1);
        cdb(2, 'h77, 0);
        cdb(0, 'h40, 0);
        chk("t4_vld_pre", 32'(commit_valid), 0);
        step();
        chk("t4_c0_vld", 32'(commit_valid), 1);
        chk("t4_c0_we", 32'(commit_we), 1);
        chk("t4_c0_dst", 32'(commit_dest), 5);
        chk("t4_c0_dat", 32'(commit_data), 'h40);
        chk("t4_c0_fl", 32'(flush), 0);
        chk("t4_c0_cnt", 32'(count), 2);
        step();
        chk("t4_c1_vld", 32'(commit_valid), 1);
        chk("t4_c1_we", 32'(commit_we), 0);
        chk("t4_c1_fl", 32'(flush), 1);
        chk("t4_c1_cnt", 32'(count), 0);
        chk("t4_c1_rdy", 32'(alloc_ready), 0);
        chk("t4_c1_head", 32'(dut.head_p), 0);
        chk("t4_c1_tail", 32'(alloc_tag), 0);
        chk("t4_c1_empty", 32'(empty), 1);
        cyc(1, 3, 0, 1, 0, 'h12, 0);
        chk("t4_drop_cnt", 32'(count), 0);
        chk("t4_drop_tail", 32'(alloc_tag), 0);
        chk("t4_drop_fl", 32'(flush), 0);
        chk("t4_drop_vld", 32'(commit_valid), 0);
        step();
        chk("t4_t2_none", 32'(commit_valid), 0);
        chk("t4_rdy_after", 32'(alloc_ready), 1);

        // 5: CDB to idle tag and repeat CDB to a done tag are ignored
        do_reset();
        cdb(0, 'hEE, 0);
        chk("t5_idle_vld", 32'(commit_valid), 0);
        chk("t5_idle_cnt", 32'(count), 0);
        alloc(4, 0);
        alloc(6, 0);
        cdb(1, 'hAB, 0);
        cdb(1, 'hCD, 0);
        cdb(0, 'h01, 0);
        chk("t5_vld_pre", 32'(commit_valid), 0);
        step();
        chk("t5_c0_vld", 32'(commit_valid), 1);
        chk("t5_c0_dst", 32'(commit_dest), 4);
        chk("t5_c0_dat", 32'(commit_data), 'h01);
        step();
        chk("t5_c1_vld", 32'(commit_valid), 1);
        chk("t5_c1_dst", 32'(commit_dest), 6);
        chk("t5_c1_dat", 32'(commit_data), 'hAB);

        // 6: asynchronous reset with a commit pending
        do_reset();
        for (int i = 0; i < 5; i++) alloc(i + 1, 0);
        cdb(0, 'h07, 0);
        chk("t6_cnt_pre", 32'(count), 5);
        #2 rst = 1'b1;
        #1;
        chk("t6_cnt", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_full", 32'(full), 0);
        chk("t6_rdy", 32'(alloc_ready), 1);
        chk("t6_tag", 32'(alloc_tag), 0);
        chk("t6_vld", 32'(commit_valid), 0);
        chk("t6_fl", 32'(flush), 0);
        @(posedge clk1);
        @(negedge clk1);
        chk("t6_vld_hold", 32'(commit_valid), 0);
        rst = 1'b0;
        step();
        chk("t6_vld_post", 32'(commit_valid), 0);
        chk("t6_cnt_post", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
